mc_core: RTL and testbench

Parametrised multi-cycle load/store core, the successor of the team's fixed-width FETCH/EXE/MEM processor. It adds configurable data, address, PC and register-file sizes, two-operand ALU ops, base+offset addressing, branches and a proper store wait state. It also gains an optional memory-wait timeout. It sits between the instruction source (indexed by `pc`) and the cache/memory port, which is transparent to it.

---
 rtl/mc_core_pkg.sv | 29 ++
 rtl/mc_core_regfile.sv | 36 +++
 rtl/mc_core.sv | 175 +++++++++++++++++
 tb/tb_mc_core.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_core_pkg.sv
// mc_core_pkg: shared encodings for the mc_core load/store core.
//   - state_t   : FSM state encoding (FETCH, EXE, MEM, ERR)
//   - OP_*      : 4-bit opcode values
//   - MEM_*     : mem_rw direction codes (IDLE/RD/WT)
package mc_core_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXE   = 2'd1,
    ST_MEM   = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SET  = 4'd1;
  localparam logic [3:0] OP_GET  = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_ST   = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_MOV  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_BEQZ = 4'd9;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_RD   = 2'd1;
  localparam logic [1:0] MEM_WT   = 2'd2;

endpackage

// File: rtl/mc_core_regfile.sv
// mc_core_regfile: REG_N x DATA_W register file.
// Ports:
//   clk, reset        - clock, synchronous active-high clear of all entries
//   we, waddr, wdata  - synchronous write port
//   a_addr -> a_data  - combinational read port (rd operand)
//   b_addr -> b_data  - combinational read port (rs operand)
module mc_core_regfile #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 4,
  parameter int RIDX_W = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RIDX_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RIDX_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data,
  input  logic [RIDX_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign a_data = regs[a_addr];
  assign b_data = regs[b_addr];

endmodule

// File: rtl/mc_core.sv
// mc_core: parametrised multi-cycle load/store core (FETCH/EXE/MEM/ERR).
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   instruction          - word at pc, latched into ir during FETCH
//   pc                   - current instruction address
//   data_out, data_valid - GET result and its one-cycle strobe
//   err                  - sticky error flag (high while in ERR)
//   mem_rw/addr/wdata    - memory request (IDLE=0, RD=1, WT=2)
//   mem_rd_en, mem_rdata - read completion and data
//   mem_wt_en            - write acceptance
// Optional feature: define MC_CORE_TIMEOUT_EN to bound MEM waits to
// TIMEOUT_CYC cycles; on expiry the core enters ERR.
//
// Memory handshake: mem_rw/mem_addr/mem_wdata are registered on the EXE edge
// and held through MEM; a transfer completes on the first clock edge in MEM
// where the enable matching mem_rw is high. The other enable is ignored, and
// both are ignored outside MEM.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int PC_W        = 8,
  parameter int REG_N       = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int RIDX_W     = $clog2(REG_N),
  localparam int INS_W      = 4 + 2 * RIDX_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INS_W-1:0]  instruction,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err,
  output logic [1:0]        mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rd_en,
  input  logic              mem_wt_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (ADDR_W > DATA_W || PC_W > DATA_W || REG_N < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("mc_core: illegal parameter combination");
  end

  state_t            state, state_next;
  logic [INS_W-1:0]  ir;
  logic [PC_W-1:0]   pc_next, pc_inc;
  logic [DATA_W-1:0] rd_data, rs_data, wdata;
  logic [ADDR_W-1:0] ls_addr;
  logic              we, get_fire, mem_start, mem_match;

  // Instruction fields, MSB to LSB: op, rd, rs, imm.
  logic [3:0]        op;
  logic [RIDX_W-1:0] rd, rs;
  logic [DATA_W-1:0] imm;
  assign op  = ir[INS_W-1 -: 4];
  assign rd  = ir[INS_W-5 -: RIDX_W];
  assign rs  = ir[DATA_W+RIDX_W-1 -: RIDX_W];
  assign imm = ir[DATA_W-1:0];

  assign pc_inc    = pc + 1'b1;
  assign ls_addr   = imm[ADDR_W-1:0] + rs_data[ADDR_W-1:0];
  // ir still holds the LD/ST during MEM, so op selects the relevant enable.
  assign mem_match = (op == OP_LD) ? mem_rd_en : mem_wt_en;
  assign err       = (state == ST_ERR);

  mc_core_regfile #(.DATA_W(DATA_W), .REG_N(REG_N), .RIDX_W(RIDX_W)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (rd),
    .wdata  (wdata),
    .a_addr (rd),
    .a_data (rd_data),
    .b_addr (rs),
    .b_data (rs_data)
  );

`ifdef MC_CORE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Held at zero outside MEM, so it is clear on every MEM entry.
  always_ff @(posedge clk) begin
    if (reset || state != ST_MEM) to_cnt <= '0;
    else                          to_cnt <= to_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    we         = 1'b0;
    wdata      = '0;
    get_fire   = 1'b0;
    mem_start  = 1'b0;
    case (state)
      ST_FETCH: state_next = ST_EXE;
      ST_EXE: begin
        state_next = ST_FETCH;
        pc_next    = pc_inc;
        case (op)
          OP_NOP: ;
          OP_SET: begin we = 1'b1; wdata = imm; end
          OP_GET: get_fire = 1'b1;
          OP_LD, OP_ST: begin
            state_next = ST_MEM;
            pc_next    = pc;
            mem_start  = 1'b1;
          end
          OP_ADD: begin we = 1'b1; wdata = rd_data + rs_data; end
          OP_SUB: begin we = 1'b1; wdata = rd_data - rs_data; end
          OP_MOV: begin we = 1'b1; wdata = rs_data; end
          OP_JMP: pc_next = imm[PC_W-1:0];
          OP_BEQZ: if (rd_data == '0) pc_next = imm[PC_W-1:0];
          default: begin
            state_next = ST_ERR;
            pc_next    = pc;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_match) begin
          state_next = ST_FETCH;
          pc_next    = pc_inc;
          if (op == OP_LD) begin
            we    = 1'b1;
            wdata = mem_rdata;
          end
        end
`ifdef MC_CORE_TIMEOUT_EN
        // A matching enable on the last allowed cycle wins over the timeout.
        else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_next = ST_ERR;
        end
`endif
      end
      ST_ERR: state_next = ST_ERR;
      default: state_next = ST_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir         <= '0;
      pc         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      mem_rw     <= MEM_IDLE;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      pc         <= pc_next;
      data_valid <= get_fire;
      if (get_fire) data_out <= rd_data;
      if (state == ST_FETCH) ir <= instruction;
      if (mem_start) begin
        mem_addr <= ls_addr;
        if (op == OP_ST) mem_wdata <= rd_data;
      end
      // Direction is driven for exactly the cycles spent in MEM.
      if (state_next == ST_MEM) mem_rw <= (op == OP_LD) ? MEM_RD : MEM_WT;
      else                      mem_rw <= MEM_IDLE;
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed test of mc_core (DATA_W=ADDR_W=PC_W=8, REG_N=4,
// TIMEOUT_CYC=4). Instructions come from a bench program array indexed by pc.
// Timeout cases are selected by MC_CORE_TIMEOUT_EN, matching the RTL build.
module tb_mc_core;
  import mc_core_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [7:0]  pc;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        err;
  logic [1:0]  mem_rw;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd_en;
  logic        mem_wt_en;
  logic [7:0]  mem_rdata;

  logic [15:0] prog [256];
  int checks = 0;
  int passes = 0;

  mc_core #(
    .DATA_W(8), .ADDR_W(8), .PC_W(8), .REG_N(4), .TIMEOUT_CYC(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .pc          (pc),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .err         (err),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rd_en   (mem_rd_en),
    .mem_wt_en   (mem_wt_en),
    .mem_rdata   (mem_rdata)
  );

  assign instruction = prog[pc];

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers. All of them start and end on a falling edge.
  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = ins(OP_NOP, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  initial begin
    reset     = 1'b1;
    mem_rd_en = 1'b0;
    mem_wt_en = 1'b0;
    mem_rdata = 8'h00;
    clear_prog();

    // Reset state
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_err", err, 0);
    check("rst_mem_rw", mem_rw, MEM_IDLE);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);

    // ALU: 0x05+0xFE=0x03; then 0xFE-0x03=0xFB moved to r0
    prog[0] = ins(OP_SET, 2'd1, 2'd0, 8'h05);
    prog[1] = ins(OP_SET, 2'd2, 2'd0, 8'hFE);
    prog[2] = ins(OP_ADD, 2'd1, 2'd2, 8'h00);
    prog[3] = ins(OP_GET, 2'd1, 2'd0, 8'h00);
    prog[4] = ins(OP_SUB, 2'd2, 2'd1, 8'h00);
    prog[5] = ins(OP_MOV, 2'd0, 2'd2, 8'h00);
    prog[6] = ins(OP_GET, 2'd0, 2'd0, 8'h00);
    tick(7);
    check("alu_dv_before_get", data_valid, 0);
    tick(1);
    check("alu_add_data", data_out, 8'h03);
    check("alu_add_dv", data_valid, 1);
    check("alu_add_pc", pc, 4);
    tick(1);
    check("alu_dv_pulse_end", data_valid, 0);
    tick(5);
    check("alu_sub_mov_data", data_out, 8'hFB);
    check("alu_sub_mov_dv", data_valid, 1);
    check("alu_sub_mov_pc", pc, 7);

    // Store with 3 wait cycles; mem_rd_en held high during waits is ignored
    clear_prog();
    do_reset();
    prog[0] = ins(OP_SET, 2'd0, 2'd0, 8'h10);
    prog[1] = ins(OP_ST,  2'd0, 2'd0, 8'h02);
    tick(4);
    check("st_rw_first", mem_rw, MEM_WT);
    check("st_addr", mem_addr, 8'h12);
    check("st_wdata", mem_wdata, 8'h10);
    check("st_pc_wait", pc, 1);
    mem_rd_en = 1'b1;
    tick(3);
    check("st_rw_last_wait", mem_rw, MEM_WT);
    check("st_pc_still", pc, 1);
    mem_rd_en = 1'b0;
    mem_wt_en = 1'b1;
    tick(1);
    mem_wt_en = 1'b0;
    check("st_rw_done", mem_rw, MEM_IDLE);
    check("st_pc_done", pc, 2);
    check("st_addr_hold", mem_addr, 8'h12);
    check("st_wdata_hold", mem_wdata, 8'h10);

    // Load at 0xF0+0x20 wraps to 0x10; mem_wt_en held high is ignored
    clear_prog();
    do_reset();
    prog[0] = ins(OP_SET, 2'd1, 2'd0, 8'hF0);
    prog[1] = ins(OP_LD,  2'd3, 2'd1, 8'h20);
    prog[2] = ins(OP_GET, 2'd3, 2'd0, 8'h00);
    mem_wt_en = 1'b1;
    mem_rdata = 8'hA5;
    tick(4);
    check("ld_rw", mem_rw, MEM_RD);
    check("ld_addr_wrap", mem_addr, 8'h10);
    tick(1);
    check("ld_wt_en_ignored", mem_rw, MEM_RD);
    mem_rd_en = 1'b1;
    tick(1);
    mem_rd_en = 1'b0;
    mem_wt_en = 1'b0;
    check("ld_rw_done", mem_rw, MEM_IDLE);
    check("ld_pc_done", pc, 2);
    tick(2);
    check("ld_get_data", data_out, 8'hA5);
    check("ld_get_dv", data_valid, 1);
    check("ld_wdata_untouched", mem_wdata, 0);

    // Branches and jumps
    clear_prog();
    do_reset();
    prog[8'h00] = ins(OP_BEQZ, 2'd0, 2'd0, 8'h20);
    prog[8'h20] = ins(OP_SET,  2'd1, 2'd0, 8'h07);
    prog[8'h21] = ins(OP_BEQZ, 2'd1, 2'd0, 8'h50);
    prog[8'h22] = ins(OP_JMP,  2'd0, 2'd0, 8'hFF);
    prog[8'hFF] = ins(OP_JMP,  2'd0, 2'd0, 8'h00);
    tick(2);
    check("beqz_taken", pc, 8'h20);
    tick(4);
    check("beqz_not_taken", pc, 8'h22);
    tick(2);
    check("jmp_ff", pc, 8'hFF);
    tick(2);
    check("jmp_ff_to_0", pc, 8'h00);

    // Straight-line wrap
    clear_prog();
    do_reset();
    prog[0] = ins(OP_JMP, 2'd0, 2'd0, 8'hFE);
    tick(2);
    check("wrap_jmp_fe", pc, 8'hFE);
    tick(4);
    check("wrap_ff_to_00", pc, 8'h00);

    // Illegal opcode, sticky ERR, reset recovery clears registers
    clear_prog();
    do_reset();
    prog[0] = ins(OP_SET, 2'd1, 2'd0, 8'h09);
    prog[1] = ins(4'hF,   2'd0, 2'd0, 8'h00);
    tick(3);
    check("ill_err_before", err, 0);
    tick(1);
    check("ill_err_set", err, 1);
    check("ill_pc_hold", pc, 1);
    tick(20);
    check("ill_err_sticky", err, 1);
    check("ill_pc_sticky", pc, 1);
    check("ill_mem_rw", mem_rw, MEM_IDLE);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("ill_reset_err", err, 0);
    check("ill_reset_pc", pc, 0);
    prog[0] = ins(OP_GET, 2'd1, 2'd0, 8'h00);
    tick(2);
    check("ill_reg_cleared", data_out, 0);
    check("ill_reg_cleared_dv", data_valid, 1);

    // Reset during MEM aborts the load
    clear_prog();
    do_reset();
    prog[0] = ins(OP_LD, 2'd2, 2'd0, 8'h10);
    mem_rdata = 8'h77;
    tick(4);
    check("abort_rw_wait", mem_rw, MEM_RD);
    reset = 1'b1;
    mem_rd_en = 1'b1;
    tick(1);
    reset = 1'b0;
    mem_rd_en = 1'b0;
    check("abort_rw_idle", mem_rw, MEM_IDLE);
    check("abort_pc", pc, 0);
    prog[0] = ins(OP_GET, 2'd2, 2'd0, 8'h00);
    tick(2);
    check("abort_reg_unwritten", data_out, 0);

`ifdef MC_CORE_TIMEOUT_EN
    // Timeout after 4 MEM cycles with no enable
    clear_prog();
    do_reset();
    prog[0] = ins(OP_LD, 2'd1, 2'd0, 8'h00);
    tick(5);
    check("to_err_before", err, 0);
    check("to_rw_before", mem_rw, MEM_RD);
    tick(1);
    check("to_err_set", err, 1);
    check("to_rw_idle", mem_rw, MEM_IDLE);
    check("to_pc_hold", pc, 0);
    // Enable on the final allowed cycle beats the timeout
    do_reset();
    mem_rdata = 8'h5A;
    tick(5);
    mem_rd_en = 1'b1;
    tick(1);
    mem_rd_en = 1'b0;
    check("to_last_cycle_err", err, 0);
    check("to_last_cycle_rw", mem_rw, MEM_IDLE);
    check("to_last_cycle_pc", pc, 1);
`else
    // Without the timeout, MEM waits indefinitely
    clear_prog();
    do_reset();
    prog[0] = ins(OP_LD, 2'd1, 2'd0, 8'h00);
    tick(22);
    check("nto_err", err, 0);
    check("nto_rw_wait", mem_rw, MEM_RD);
    mem_rd_en = 1'b1;
    tick(1);
    mem_rd_en = 1'b0;
    check("nto_rw_done", mem_rw, MEM_IDLE);
    check("nto_pc", pc, 1);
`endif

    // Final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
